// File: rtl/lcd_line_prefetch_ctrl.sv
// Line prefetch sequencer for the RGB LCD path: keeps two ping-pong line buffers
// filled ahead of the scan by issuing one burst read per line to the memory arbiter.
module lcd_line_prefetch_ctrl #(
  parameter int H_DISP      = 800,
  parameter int V_DISP      = 480,
  parameter int ADDR_W      = 24,
  parameter int BASE_ADDR   = 0,
  parameter int LINE_STRIDE = 800
) (
  input  logic              lcd_pclk,
  input  logic              rst,
  input  logic              en,
  input  logic              frame_start,
  input  logic              line_done,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [10:0]       rd_len,
  input  logic              rd_ack,
  input  logic              rd_done,
  output logic              wr_buf_sel,
  output logic              disp_buf_sel,
  output logic [1:0]        buf_valid,
  output logic              frame_active,
  output logic              underflow,
  output logic [1:0]        dbg_state
);

  localparam logic [10:0]       LINES_W  = 11'(V_DISP);
  localparam logic [10:0]       LEN_W    = 11'(H_DISP);
  localparam logic [ADDR_W-1:0] BASE_W   = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] STRIDE_W = ADDR_W'(LINE_STRIDE);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_XFER = 2'd2
  } state_t;

  // Handshake: rd_req rises from IDLE and stays high, with rd_addr stable, until
  // the edge that samples rd_ack; the burst then ends on the edge sampling rd_done.
  state_t              state_q, state_d;
  logic                rd_req_q, rd_req_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic                wr_buf_sel_q, wr_buf_sel_d;
  logic                disp_buf_sel_q, disp_buf_sel_d;
  logic [1:0]          buf_valid_q, buf_valid_d;
  logic                frame_active_q, frame_active_d;
  logic                underflow_q, underflow_d;
  logic                restart_pend_q, restart_pend_d;
  logic [10:0]         fetch_line_q, fetch_line_d;
  logic [10:0]         disp_line_q, disp_line_d;

  logic                do_restart;
  logic                do_fill;
  logic                do_consume;

  always_comb begin
    state_d        = state_q;
    rd_req_d       = rd_req_q;
    rd_addr_d      = rd_addr_q;
    wr_buf_sel_d   = wr_buf_sel_q;
    disp_buf_sel_d = disp_buf_sel_q;
    buf_valid_d    = buf_valid_q;
    frame_active_d = frame_active_q;
    underflow_d    = underflow_q;
    restart_pend_d = restart_pend_q;
    fetch_line_d   = fetch_line_q;
    disp_line_d    = disp_line_q;
    do_restart     = 1'b0;
    do_fill        = 1'b0;
    do_consume     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          do_restart = 1'b1;
        end else if (frame_active_q && en && (fetch_line_q < LINES_W) &&
                     !buf_valid_q[wr_buf_sel_q] && !restart_pend_q) begin
          state_d  = S_REQ;
          rd_req_d = 1'b1;
        end
      end
      S_REQ: begin
        if (frame_start) restart_pend_d = 1'b1;
        if (rd_ack) begin
          rd_req_d = 1'b0;
          state_d  = S_XFER;
        end
      end
      S_XFER: begin
        if (frame_start) restart_pend_d = 1'b1;
        if (rd_done) begin
          state_d = S_IDLE;
          // A burst that straddles a new frame is drained but its data is stale.
          if (restart_pend_q || frame_start) do_restart = 1'b1;
          else                               do_fill    = 1'b1;
        end
      end
      default: begin
        state_d  = S_IDLE;
        rd_req_d = 1'b0;
      end
    endcase

    do_consume = line_done && frame_active_q && (disp_line_q < LINES_W);

    if (do_consume) begin
      if (!buf_valid_q[disp_buf_sel_q]) underflow_d = 1'b1;
      buf_valid_d[disp_buf_sel_q] = 1'b0;
      disp_buf_sel_d = ~disp_buf_sel_q;
      disp_line_d    = disp_line_q + 11'd1;
      if (disp_line_q + 11'd1 == LINES_W) frame_active_d = 1'b0;
    end

    // Applied after the release so a same-buffer fill wins.
    if (do_fill) begin
      buf_valid_d[wr_buf_sel_q] = 1'b1;
      wr_buf_sel_d = ~wr_buf_sel_q;
      fetch_line_d = fetch_line_q + 11'd1;
      rd_addr_d    = rd_addr_q + STRIDE_W;
    end

    // Frame restart overrides everything except the sticky underflow flag.
    if (do_restart) begin
      fetch_line_d   = 11'd0;
      disp_line_d    = 11'd0;
      wr_buf_sel_d   = 1'b0;
      disp_buf_sel_d = 1'b0;
      buf_valid_d    = 2'b00;
      rd_addr_d      = BASE_W;
      frame_active_d = 1'b1;
      restart_pend_d = 1'b0;
    end
  end

  always_ff @(posedge lcd_pclk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      rd_req_q       <= 1'b0;
      rd_addr_q      <= BASE_W;
      wr_buf_sel_q   <= 1'b0;
      disp_buf_sel_q <= 1'b0;
      buf_valid_q    <= 2'b00;
      frame_active_q <= 1'b0;
      underflow_q    <= 1'b0;
      restart_pend_q <= 1'b0;
      fetch_line_q   <= 11'd0;
      disp_line_q    <= 11'd0;
    end else begin
      state_q        <= state_d;
      rd_req_q       <= rd_req_d;
      rd_addr_q      <= rd_addr_d;
      wr_buf_sel_q   <= wr_buf_sel_d;
      disp_buf_sel_q <= disp_buf_sel_d;
      buf_valid_q    <= buf_valid_d;
      frame_active_q <= frame_active_d;
      underflow_q    <= underflow_d;
      restart_pend_q <= restart_pend_d;
      fetch_line_q   <= fetch_line_d;
      disp_line_q    <= disp_line_d;
    end
  end

  assign rd_req       = rd_req_q;
  assign rd_addr      = rd_addr_q;
  assign rd_len       = LEN_W;
  assign wr_buf_sel   = wr_buf_sel_q;
  assign disp_buf_sel = disp_buf_sel_q;
  assign buf_valid    = buf_valid_q;
  assign frame_active = frame_active_q;
  assign underflow    = underflow_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_lcd_line_prefetch_ctrl.sv
// Bench for lcd_line_prefetch_ctrl: directed vector table, hand sequences for the
// multi-cycle corners, and a randomized frame against a line-count reference model.
module tb_lcd_line_prefetch_ctrl;

  localparam int H_DISP      = 800;
  localparam int V_DISP      = 480;
  localparam int BASE_ADDR   = 0;
  localparam int LINE_STRIDE = 800;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        frame_start;
  logic        line_done;
  logic        rd_ack;
  logic        rd_done;
  logic        rd_req;
  logic [23:0] rd_addr;
  logic [10:0] rd_len;
  logic        wr_buf_sel;
  logic        disp_buf_sel;
  logic [1:0]  buf_valid;
  logic        frame_active;
  logic        underflow;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  logic [23:0] exp_q[$];

  typedef struct {
    logic        fs, en, ld, ack, dn;
    logic        e_req;
    logic [23:0] e_addr;
    logic [1:0]  e_bv;
    logic        e_wr, e_disp, e_fa, e_uf;
  } vec_t;
  vec_t vecs[$];

  lcd_line_prefetch_ctrl dut (
    .lcd_pclk     (clk),
    .rst          (rst),
    .en           (en),
    .frame_start  (frame_start),
    .line_done    (line_done),
    .rd_req       (rd_req),
    .rd_addr      (rd_addr),
    .rd_len       (rd_len),
    .rd_ack       (rd_ack),
    .rd_done      (rd_done),
    .wr_buf_sel   (wr_buf_sel),
    .disp_buf_sel (disp_buf_sel),
    .buf_valid    (buf_valid),
    .frame_active (frame_active),
    .underflow    (underflow),
    .dbg_state    (dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected $finish before 2ms");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void add_vec(input logic fs, input logic ld, input logic ack, input logic dn,
                                  input logic req, input logic [23:0] addr, input logic [1:0] bv,
                                  input logic wr, input logic disp, input logic fa, input logic uf);
    vec_t v;
    v.fs = fs; v.en = 1'b1; v.ld = ld; v.ack = ack; v.dn = dn;
    v.e_req = req; v.e_addr = addr; v.e_bv = bv;
    v.e_wr = wr; v.e_disp = disp; v.e_fa = fa; v.e_uf = uf;
    vecs.push_back(v);
  endfunction

  // Driver tasks: inputs change 1 time unit after the edge, outputs sampled there too.
  task automatic cyc(input logic fs, input logic ld, input logic ack, input logic dn);
    frame_start = fs; line_done = ld; rd_ack = ack; rd_done = dn;
    @(posedge clk);
    #1;
    frame_start = 1'b0; line_done = 1'b0; rd_ack = 1'b0; rd_done = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; frame_start = 1'b0; line_done = 1'b0; rd_ack = 1'b0; rd_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.rd_req", 32'(rd_req), 32'(0));
    check("rst.rd_addr", 32'(rd_addr), 32'(BASE_ADDR));
    check("rst.rd_len", 32'(rd_len), 32'(H_DISP));
    check("rst.bufsel", 32'({wr_buf_sel, disp_buf_sel}), 32'(0));
    check("rst.buf_valid", 32'(buf_valid), 32'(0));
    check("rst.frame_active", 32'(frame_active), 32'(0));
    check("rst.underflow", 32'(underflow), 32'(0));
    rst = 1'b0;
  endtask

  task automatic wait_req(input string name, input int budget);
    int k = 0;
    while (!rd_req && k < budget) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      k++;
    end
    check(name, 32'(rd_req), 32'(1));
  endtask

  task automatic serve_line(input string name);
    wait_req(name, 10);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Full frame with a responding arbiter. The model tracks only line counts:
  // f lines fetched, c lines consumed, p = request phase (0 none, 1 asked, 2 bursting).
  task automatic run_frame(input bit rmode);
    int f, c, p, nf, nc, np, cyc_n, tail, ack_cnt, done_cnt, reqs;
    bit on, uf, in_burst, issue;
    logic a_ack, a_done, a_ld, a_en;
    logic [23:0] last_addr, exp_addr;
    logic [1:0] eb;
    f = 0; c = 0; p = 0; on = 1'b1; uf = 1'b0; in_burst = 1'b0;
    cyc_n = 0; tail = 0; reqs = 0; done_cnt = 0; last_addr = '0;
    ack_cnt = rmode ? int'($urandom_range(0, 3)) : 0;
    exp_q.delete();
    for (int k = 0; k < V_DISP; k++) exp_q.push_back(24'(BASE_ADDR + k * LINE_STRIDE));
    while (tail < 10 && cyc_n < 30000 && n_bad < 50) begin
      a_ack = 1'b0; a_done = 1'b0; a_ld = 1'b0;
      a_en = rmode ? ($urandom_range(0, 7) != 0) : 1'b1;
      if (in_burst) begin
        if (done_cnt == 0) begin
          a_done = 1'b1; in_burst = 1'b0;
          ack_cnt = rmode ? int'($urandom_range(0, 3)) : 0;
        end else done_cnt--;
        if (rmode && $urandom_range(0, 15) == 0) a_ack = 1'b1;
      end else if (rd_req) begin
        if (ack_cnt == 0) begin
          a_ack = 1'b1; in_burst = 1'b1; reqs++; last_addr = rd_addr;
          done_cnt = rmode ? int'($urandom_range(0, 5)) : 0;
          if (exp_q.size() > 0) check("rf.req_addr", 32'(rd_addr), 32'(exp_q.pop_front()));
          else check("rf.req_count_excess", 32'(reqs), 32'(V_DISP));
        end else ack_cnt--;
      end else if (rmode && $urandom_range(0, 15) == 0) a_done = 1'b1;
      if (c < f && (rmode ? ($urandom_range(0, 2) == 0) : (cyc_n % 8 == 0))) a_ld = 1'b1;

      en = a_en; rd_ack = a_ack; rd_done = a_done; line_done = a_ld;
      @(posedge clk);
      issue = (p == 0) && on && a_en && (f < V_DISP) && (f - c < 2);
      np = p; nf = f; nc = c;
      if (issue) np = 1;
      if (p == 1 && a_ack) np = 2;
      if (p == 2 && a_done) begin nf = f + 1; np = 0; end
      if (a_ld && on && c < V_DISP) begin
        if (c >= f) uf = 1'b1;
        nc = c + 1;
        if (nc == V_DISP) on = 1'b0;
      end
      p = np; f = nf; c = nc;
      #1;
      rd_ack = 1'b0; rd_done = 1'b0; line_done = 1'b0;

      exp_addr = 24'(BASE_ADDR + f * LINE_STRIDE);
      eb = 2'b00;
      for (int k = c; k < f; k++) eb[k % 2] = 1'b1;
      check("rf.rd_req", 32'(rd_req), 32'(p == 1));
      check("rf.rd_addr", 32'(rd_addr), 32'(exp_addr));
      check("rf.buf_valid", 32'(buf_valid), 32'(eb));
      check("rf.wr_buf_sel", 32'(wr_buf_sel), 32'(f % 2));
      check("rf.disp_buf_sel", 32'(disp_buf_sel), 32'(c % 2));
      check("rf.frame_active", 32'(frame_active), 32'(on));
      check("rf.underflow", 32'(underflow), 32'(uf));
      cyc_n++;
      if (c >= V_DISP) tail++;
    end
    en = 1'b1;
    check("rf.lines_consumed", 32'(c), 32'(V_DISP));
    check("rf.req_count", 32'(reqs), 32'(V_DISP));
    check("rf.last_addr", 32'(last_addr), 32'(BASE_ADDR + (V_DISP - 1) * LINE_STRIDE));
    check("rf.addr_left", 32'(exp_q.size()), 32'(0));
    check("rf.frame_active_end", 32'(frame_active), 32'(0));
    check("rf.underflow_end", 32'(underflow), 32'(0));
  endtask

  initial begin
    int seen;
    rst = 1'b1; en = 1'b1;
    frame_start = 1'b0; line_done = 1'b0; rd_ack = 1'b0; rd_done = 1'b0;

    // fs ld ack dn | req addr bv wr disp fa uf
    add_vec(0, 0, 0, 0, 0,    0, 2'b00, 0, 0, 0, 0);
    add_vec(1, 0, 0, 0, 0,    0, 2'b00, 0, 0, 1, 0);
    add_vec(0, 0, 0, 0, 1,    0, 2'b00, 0, 0, 1, 0);
    add_vec(0, 0, 0, 0, 1,    0, 2'b00, 0, 0, 1, 0);
    add_vec(0, 0, 0, 0, 1,    0, 2'b00, 0, 0, 1, 0);
    add_vec(0, 0, 1, 0, 0,    0, 2'b00, 0, 0, 1, 0);
    add_vec(0, 0, 0, 0, 0,    0, 2'b00, 0, 0, 1, 0);
    add_vec(0, 0, 0, 1, 0,  800, 2'b01, 1, 0, 1, 0);
    add_vec(0, 0, 0, 0, 1,  800, 2'b01, 1, 0, 1, 0);
    add_vec(0, 0, 1, 0, 0,  800, 2'b01, 1, 0, 1, 0);
    add_vec(0, 0, 0, 1, 0, 1600, 2'b11, 0, 0, 1, 0);
    add_vec(0, 0, 0, 0, 0, 1600, 2'b11, 0, 0, 1, 0);
    add_vec(0, 0, 0, 0, 0, 1600, 2'b11, 0, 0, 1, 0);
    add_vec(0, 1, 0, 0, 0, 1600, 2'b10, 0, 1, 1, 0);
    add_vec(0, 0, 0, 0, 1, 1600, 2'b10, 0, 1, 1, 0);
    add_vec(0, 0, 1, 0, 0, 1600, 2'b10, 0, 1, 1, 0);
    add_vec(0, 0, 0, 1, 0, 2400, 2'b11, 1, 1, 1, 0);
    add_vec(0, 1, 0, 0, 0, 2400, 2'b01, 1, 0, 1, 0);
    add_vec(0, 0, 0, 0, 1, 2400, 2'b01, 1, 0, 1, 0);
    add_vec(0, 1, 1, 0, 0, 2400, 2'b00, 1, 1, 1, 0);
    add_vec(0, 1, 0, 1, 0, 3200, 2'b10, 0, 0, 1, 1);
    add_vec(0, 0, 0, 0, 1, 3200, 2'b10, 0, 0, 1, 1);

    do_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      en = vecs[i].en;
      cyc(vecs[i].fs, vecs[i].ld, vecs[i].ack, vecs[i].dn);
      check($sformatf("vec%0d.rd_req", i), 32'(rd_req), 32'(vecs[i].e_req));
      check($sformatf("vec%0d.rd_addr", i), 32'(rd_addr), 32'(vecs[i].e_addr));
      check($sformatf("vec%0d.buf_valid", i), 32'(buf_valid), 32'(vecs[i].e_bv));
      check($sformatf("vec%0d.wr_buf_sel", i), 32'(wr_buf_sel), 32'(vecs[i].e_wr));
      check($sformatf("vec%0d.disp_buf_sel", i), 32'(disp_buf_sel), 32'(vecs[i].e_disp));
      check($sformatf("vec%0d.frame_active", i), 32'(frame_active), 32'(vecs[i].e_fa));
      check($sformatf("vec%0d.underflow", i), 32'(underflow), 32'(vecs[i].e_uf));
    end

    // Whole frame with a fast arbiter, then one line_done too many.
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    run_frame(1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    check("extra_ld.frame_active", 32'(frame_active), 32'(0));
    check("extra_ld.disp_buf_sel", 32'(disp_buf_sel), 32'(0));
    check("extra_ld.buf_valid", 32'(buf_valid), 32'(0));
    check("extra_ld.underflow", 32'(underflow), 32'(0));
    check("extra_ld.rd_req", 32'(rd_req), 32'(0));

    // Randomized arbiter latency, enable and line_done timing.
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    run_frame(1'b1);

    // Underflow is sticky across frame_start and cleared only by reset.
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    serve_line("uf.req0");
    wait_req("uf.req1", 5);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    check("uf.after_good_ld", 32'(underflow), 32'(0));
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    check("uf.set", 32'(underflow), 32'(1));
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("uf.after_done", 32'(underflow), 32'(1));
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check("uf.after_fs", 32'(underflow), 32'(1));
    check("uf.fs_buf_valid", 32'(buf_valid), 32'(0));
    repeat (5) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("uf.hold", 32'(underflow), 32'(1));
    do_reset();

    // frame_start while line 5 is bursting: drained, discarded, then restart.
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    serve_line("fs.req0");
    serve_line("fs.req1");
    for (int k = 2; k <= 4; k++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      serve_line($sformatf("fs.req%0d", k));
    end
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    wait_req("fs.req5", 10);
    check("fs.req5_addr", 32'(rd_addr), 32'(BASE_ADDR + 5 * LINE_STRIDE));
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check("fs.pend_buf_valid", 32'(buf_valid), 32'(2'b01));
    check("fs.pend_rd_req", 32'(rd_req), 32'(0));
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("fs.restart_buf_valid", 32'(buf_valid), 32'(0));
    check("fs.restart_sel", 32'({wr_buf_sel, disp_buf_sel}), 32'(0));
    check("fs.restart_active", 32'(frame_active), 32'(1));
    wait_req("fs.req_new", 3);
    check("fs.req_new_addr", 32'(rd_addr), 32'(BASE_ADDR));
    check("fs.req_new_wr", 32'(wr_buf_sel), 32'(0));

    // en dropped after the first ack: burst completes, no new request until en returns.
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    wait_req("en.req0", 5);
    check("en.req0_addr", 32'(rd_addr), 32'(BASE_ADDR));
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    en = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("en.burst0_valid", 32'(buf_valid), 32'(2'b01));
    seen = 0;
    repeat (10) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      if (rd_req) seen++;
    end
    check("en.no_req_while_low", 32'(seen), 32'(0));
    en = 1'b1;
    wait_req("en.req1", 2);
    check("en.req1_addr", 32'(rd_addr), 32'(BASE_ADDR + LINE_STRIDE));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
